rc4_xor_stream: RTL and testbench

- Consumer end of the rc4 core's keystream output: takes keystream bytes from the core and XORs them onto a data byte stream.
- Performs encryption or decryption; the operation is symmetric, so there is no mode input.
- Sits between the rc4 core (keystream side) and the system datapath (din/dout side).
- Processes one message of programmable length per start pulse, using valid/ready handshakes on all three streams.

---
 rtl/rc4_pkg.sv | 8 +
 rtl/rc4_ks_fifo.sv | 35 +++
 rtl/rc4_xor_stream.sv | 81 ++++++++
 tb/tb_rc4_xor_stream.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rc4_pkg: shared byte width and state encoding for the rc4 keystream consumer
package rc4_pkg;
  localparam int BYTE_W = 8;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/rc4_ks_fifo.sv
// rc4_ks_fifo: DEPTH x byte keystream FIFO (push/din in, pop/head out, full/empty flags)
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] head,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign head  = mem[rp];
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= push ? wp + AW'(1) : wp;
      rp  <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/rc4_xor_stream.sv
// rc4_xor_stream: XORs rc4 keystream (ks_*) onto a data stream (din_* -> dout_*), one message of msg_len bytes per start
module rc4_xor_stream
  import rc4_pkg::*;
#(
  parameter int KS_DEPTH = 4,
  parameter int LEN_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              ks_valid,
  input  logic [BYTE_W-1:0] ks_data,
  output logic              ks_ready,
  input  logic              din_valid,
  input  logic [BYTE_W-1:0] din_data,
  output logic              din_ready,
  output logic              dout_valid,
  output logic [BYTE_W-1:0] dout_data,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  byte_cnt
);
  state_t state;
  logic [LEN_W-1:0] len, ks_cnt, in_cnt;
  logic [BYTE_W-1:0] head;
  logic full, empty, ks_xfer, out_xfer;
  assign ks_ready  = state == ST_RUN && !full && ks_cnt < len;
  assign din_ready = state == ST_RUN && !empty && din_valid && in_cnt < len && (!dout_valid || dout_ready);
  assign ks_xfer   = ks_valid && ks_ready;
  assign out_xfer  = dout_valid && dout_ready;
  rc4_ks_fifo #(.DEPTH(KS_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ks_xfer),
    .pop   (din_ready),
    .din   (ks_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_IDLE;
      len        <= '0;
      ks_cnt     <= '0;
      in_cnt     <= '0;
      byte_cnt   <= '0;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ks_cnt     <= ks_xfer ? ks_cnt + LEN_W'(1) : ks_cnt;
      in_cnt     <= din_ready ? in_cnt + LEN_W'(1) : in_cnt;
      byte_cnt   <= out_xfer ? byte_cnt + LEN_W'(1) : byte_cnt;
      dout_data  <= din_ready ? din_data ^ head : dout_data;
      dout_valid <= din_ready || (dout_valid && !dout_ready);
      case (state)
        ST_IDLE: if (start) begin
          len      <= msg_len;
          ks_cnt   <= '0;
          in_cnt   <= '0;
          byte_cnt <= '0;
          state    <= msg_len != '0 ? ST_RUN : ST_DONE;
          busy     <= msg_len != '0;
          done     <= msg_len == '0;
        end
        ST_RUN: if (out_xfer && byte_cnt + LEN_W'(1) == len) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_rc4_xor_stream.sv
// tb_rc4_xor_stream: table-driven check of rc4_xor_stream plus directed corner-case sequences
module tb_rc4_xor_stream;
  localparam int LEN_W = 16;
  localparam int KS = 4;
  logic clk = 0, rst_n = 0, start = 0;
  logic [LEN_W-1:0] msg_len = '0;
  logic ks_valid = 0, din_valid = 0, dout_ready = 0;
  logic [7:0] ks_data = '0, din_data = '0;
  logic ks_ready, din_ready, dout_valid, busy, done;
  logic [7:0] dout_data;
  logic [LEN_W-1:0] byte_cnt;
  int tests = 0, fails = 0;
  typedef struct {
    int len;
    logic [8:0][7:0] ks;
    logic [8:0][7:0] din;
    logic [8:0][7:0] exp;
    logic [3:0] rdy;
    bit want_full;
  } vec_t;
  vec_t vecs[4];
  logic [7:0] ks_b[9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
  logic [7:0] pt_b[9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct_b[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  rc4_xor_stream #(.KS_DEPTH(KS), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .msg_len    (msg_len),
    .ks_valid   (ks_valid),
    .ks_data    (ks_data),
    .ks_ready   (ks_ready),
    .din_valid  (din_valid),
    .din_data   (din_data),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout_data  (dout_data),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .byte_cnt   (byte_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_start(input int len);
    @(negedge clk);
    start = 1;
    msg_len = LEN_W'(len);
    @(negedge clk);
    start = 0;
  endtask
  task automatic run(input int v, input int abort);
    int ki, di, oi, dones, len;
    logic stall, kt, dt;
    logic [7:0] held;
    bit saw_full;
    ki = 0; di = 0; oi = 0; dones = 0; stall = 0; held = '0; saw_full = 0;
    len = vecs[v].len;
    pulse_start(len);
    for (int c = 0; c < 200; c++) begin
      if (abort > 0 && oi == abort) begin
        rst_n = 0;
        ks_valid = 0;
        din_valid = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_dout_data", dout_data, 0);
        @(negedge clk);
        rst_n = 1;
        return;
      end
      ks_valid = ki < len;
      ks_data = ki < len ? vecs[v].ks[ki] : 8'h00;
      din_valid = di < len;
      din_data = di < len ? vecs[v].din[di] : 8'h00;
      dout_ready = vecs[v].rdy[c % 4];
      #1;
      chk("ks_ready", ks_ready, oi < len && ki - di < KS && ki < len);
      if (stall) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_data", dout_data, held);
      end
      stall = dout_valid && !dout_ready;
      held = dout_data;
      if (!ks_ready && ki - di == KS && ki < len) saw_full = 1;
      if (dout_valid && dout_ready) begin
        if (oi < len) chk($sformatf("dout[%0d]", oi), dout_data, vecs[v].exp[oi]);
        oi++;
      end
      if (done) begin
        chk("done_after_last", oi, len);
        dones++;
        break;
      end
      kt = ks_valid && ks_ready;
      dt = din_valid && din_ready;
      @(negedge clk);
      ki += int'(kt);
      di += int'(dt);
    end
    chk("out_count", oi, len);
    chk("done_count", dones, 1);
    chk("byte_cnt", byte_cnt, len);
    if (vecs[v].want_full) chk("ks_full_seen", saw_full, 1);
    ks_valid = 0;
    din_valid = 0;
    @(negedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("byte_cnt_hold", byte_cnt, len);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int kx, dx, ox;
    bit seen;
    for (int i = 0; i < 9; i++) begin
      vecs[0].ks[i] = ks_b[i]; vecs[0].din[i] = pt_b[i]; vecs[0].exp[i] = ct_b[i];
      vecs[1].ks[i] = ks_b[i]; vecs[1].din[i] = ct_b[i]; vecs[1].exp[i] = pt_b[i];
      vecs[2].ks[i] = ks_b[i]; vecs[2].din[i] = pt_b[i]; vecs[2].exp[i] = ct_b[i];
      vecs[3].ks[i] = ks_b[i]; vecs[3].din[i] = ct_b[i]; vecs[3].exp[i] = pt_b[i];
    end
    vecs[0].len = 9; vecs[0].rdy = 4'b1111; vecs[0].want_full = 0;
    vecs[1].len = 9; vecs[1].rdy = 4'b1111; vecs[1].want_full = 0;
    vecs[2].len = 9; vecs[2].rdy = 4'b1001; vecs[2].want_full = 1;
    vecs[3].len = 9; vecs[3].rdy = 4'b0110; vecs[3].want_full = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ks_ready", ks_ready, 0);
    chk("reset_din_ready", din_ready, 0);
    chk("reset_dout_valid", dout_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dout_data", dout_data, 0);
    chk("reset_byte_cnt", byte_cnt, 0);
    rst_n = 1;
    for (int v = 0; v < 4; v++) run(v, 0);
    // zero-length message: straight to DONE, nothing drawn
    ks_valid = 1;
    din_valid = 1;
    dout_ready = 1;
    pulse_start(0);
    #1;
    chk("zero_done", done, 1);
    chk("zero_ks_ready", ks_ready, 0);
    chk("zero_din_ready", din_ready, 0);
    chk("zero_byte_cnt", byte_cnt, 0);
    @(negedge clk);
    #1;
    chk("zero_done_pulse", done, 0);
    chk("zero_ks_ready_after", ks_ready, 0);
    // over-draw guard with a second start pulsed during RUN
    ks_valid = 0;
    din_valid = 0;
    pulse_start(3);
    kx = 0;
    ks_valid = 1;
    for (int c = 0; c < 10; c++) begin
      ks_data = 8'hA0 + 8'(kx);
      start = c == 4;
      msg_len = c == 4 ? LEN_W'(9) : LEN_W'(3);
      #1;
      if (ks_ready) kx++;
      @(negedge clk);
    end
    start = 0;
    #1;
    chk("overdraw_count", kx, 3);
    chk("overdraw_ks_ready", ks_ready, 0);
    ks_valid = 0;
    dx = 0;
    ox = 0;
    seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      din_valid = 1;
      din_data = 8'h10 + 8'(dx);
      #1;
      if (din_ready) dx++;
      if (dout_valid && dout_ready) begin
        chk("overdraw_dout", dout_data, (8'h10 + 8'(ox)) ^ (8'hA0 + 8'(ox)));
        ox++;
      end
      seen = done;
      @(negedge clk);
    end
    din_valid = 0;
    chk("ignored_start_outs", ox, 3);
    chk("ignored_start_done", seen, 1);
    chk("ignored_start_byte_cnt", byte_cnt, 3);
    // reset mid-message, then a clean rerun of the first vector
    run(0, 2);
    run(0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
